// File: rtl/lcd_cmd_sequencer.sv
// Command sequencer for an HD44780-style LCD: accepts opcodes, sequences
// command/data bytes to a byte driver and paces the long waits via counter flags.
module lcd_cmd_sequencer #(
  parameter int NFLAGS = 7,
  parameter int MODE   = 1,
  parameter int LINES  = 1,
  parameter int FONT   = 0,
  parameter int F_PWR  = 0,
  parameter int F_LONG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd_in,
  input  logic [7:0]        cmd_arg,
  input  logic              cmd_valid,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              driver_rdy,
  output logic              cmd_ready,
  output logic              busy,
  output logic              init_done,
  output logic              ctrl_error,
  output logic              nctrl_count,
  output logic              ctrl_sel_count,
  output logic [1:0]        ctrl_sel_data,
  output logic              ctrl_enable_driver,
  output logic              ctrl_rs,
  output logic [7:0]        ctrl_cmd
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_INIT   = 4'd1;
  localparam logic [3:0] OP_CONFIG = 4'd2;
  localparam logic [3:0] OP_SEND   = 4'd3;
  localparam logic [3:0] OP_CLEAR  = 4'd4;
  localparam logic [3:0] OP_HOME   = 4'd5;
  localparam logic [3:0] OP_SHIFT  = 4'd6;
  localparam logic [3:0] OP_OFF    = 4'd7;

  localparam logic MODE_B  = (MODE != 0);
  localparam logic LINES_B = (LINES != 0);
  localparam logic FONT_B  = (FONT != 0);
  localparam logic [7:0] SETUP = {3'b001, ~MODE_B, LINES_B, FONT_B, 2'b00};

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    ISSUE,
    LONG_WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] op;
  logic [7:0] arg;
  logic [1:0] byte_idx;
  logic       cmd_legal;
  logic       last_byte;
  logic       needs_long;

  function automatic logic [7:0] byte_for(input logic [3:0] f_op, input logic [7:0] f_arg,
                                          input logic [1:0] f_idx);
    logic [7:0] b;
    b = 8'h00;
    case (f_op)
      OP_INIT: begin
        case (f_idx)
          2'd0:    b = SETUP;
          2'd1:    b = 8'h06;
          2'd2:    b = 8'h0C;
          default: b = 8'h01;
        endcase
      end
      OP_CONFIG: b = {5'b00001, f_arg[2:0]};
      OP_SEND:   b = f_arg;
      OP_CLEAR:  b = 8'h01;
      OP_HOME:   b = 8'h02;
      OP_SHIFT:  b = {4'b0001, f_arg[1:0], 2'b00};
      OP_OFF:    b = 8'h08;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // NOP and INIT are always legal; everything else needs a completed INIT
  assign cmd_legal  = !cmd_in[3] && ((cmd_in <= OP_INIT) || init_done);
  assign last_byte  = (op == OP_INIT) ? (byte_idx == 2'd3) : 1'b1;
  assign needs_long = (op == OP_INIT) || (op == OP_CLEAR) || (op == OP_HOME);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      op                 <= OP_NOP;
      arg                <= 8'h00;
      byte_idx           <= 2'd0;
      cmd_ready          <= 1'b1;
      init_done          <= 1'b0;
      ctrl_error         <= 1'b0;
      nctrl_count        <= 1'b1;
      ctrl_sel_count     <= 1'b0;
      ctrl_sel_data      <= 2'b00;
      ctrl_enable_driver <= 1'b0;
      ctrl_rs            <= 1'b0;
      ctrl_cmd           <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (!cmd_legal) begin
              ctrl_error <= 1'b1;
            end else begin
              ctrl_error <= 1'b0;
              op         <= cmd_in;
              arg        <= cmd_arg;
              byte_idx   <= 2'd0;
              cmd_ready  <= 1'b0;
              if (cmd_in == OP_NOP) begin
                state <= DONE;
              end else if (cmd_in == OP_INIT) begin
                state          <= PWR_WAIT;
                nctrl_count    <= 1'b0;
                ctrl_sel_count <= 1'b0;
              end else begin
                state          <= ISSUE;
                ctrl_sel_count <= 1'b1;
              end
            end
          end
        end
        PWR_WAIT: begin
          if (flags_in[F_PWR]) begin
            state          <= ISSUE;
            nctrl_count    <= 1'b1;
            ctrl_sel_count <= 1'b1;
          end
        end
        // Each byte gets a load cycle with enable low, so enable always
        // drops for at least one cycle between consecutive bytes.
        ISSUE: begin
          if (!ctrl_enable_driver) begin
            ctrl_cmd           <= byte_for(op, arg, byte_idx);
            ctrl_rs            <= (op == OP_SEND);
            ctrl_sel_data      <= (op == OP_SEND) ? 2'b10 : 2'b01;
            ctrl_enable_driver <= 1'b1;
          end else if (driver_rdy) begin
            ctrl_enable_driver <= 1'b0;
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
            end else if (needs_long) begin
              state          <= LONG_WAIT;
              nctrl_count    <= 1'b0;
              ctrl_sel_count <= 1'b0;
            end else begin
              state          <= DONE;
              ctrl_sel_count <= 1'b0;
            end
          end
        end
        LONG_WAIT: begin
          if (flags_in[F_LONG]) begin
            state       <= DONE;
            nctrl_count <= 1'b1;
          end
        end
        DONE: begin
          state              <= IDLE;
          cmd_ready          <= 1'b1;
          ctrl_sel_data      <= 2'b00;
          ctrl_enable_driver <= 1'b0;
          if (op == OP_INIT) init_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed testbench for lcd_cmd_sequencer: init sequence, data/command bytes,
// error handling, busy-time request filtering, async reset and alternate SETUP.
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd_in = 4'd0;
  logic [7:0] cmd_arg = 8'h00;
  logic       cmd_valid = 1'b0;
  logic [6:0] flags_in = 7'd0;
  logic       driver_rdy = 1'b0;
  logic       cmd_valid2 = 1'b0;
  logic       driver_rdy2 = 1'b0;

  logic       cmd_ready, busy, init_done, ctrl_error, nctrl_count, ctrl_sel_count;
  logic       ctrl_enable_driver, ctrl_rs;
  logic [1:0] ctrl_sel_data;
  logic [7:0] ctrl_cmd;
  logic       cmd_ready2, busy2, init_done2, ctrl_error2, nctrl_count2, ctrl_sel_count2;
  logic       ctrl_enable_driver2, ctrl_rs2;
  logic [1:0] ctrl_sel_data2;
  logic [7:0] ctrl_cmd2;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid),
    .flags_in(flags_in), .driver_rdy(driver_rdy), .cmd_ready(cmd_ready), .busy(busy),
    .init_done(init_done), .ctrl_error(ctrl_error), .nctrl_count(nctrl_count),
    .ctrl_sel_count(ctrl_sel_count), .ctrl_sel_data(ctrl_sel_data),
    .ctrl_enable_driver(ctrl_enable_driver), .ctrl_rs(ctrl_rs), .ctrl_cmd(ctrl_cmd)
  );

  lcd_cmd_sequencer #(.MODE(0), .LINES(0), .FONT(1)) dut_alt (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid2),
    .flags_in(flags_in), .driver_rdy(driver_rdy2), .cmd_ready(cmd_ready2), .busy(busy2),
    .init_done(init_done2), .ctrl_error(ctrl_error2), .nctrl_count(nctrl_count2),
    .ctrl_sel_count(ctrl_sel_count2), .ctrl_sel_data(ctrl_sel_data2),
    .ctrl_enable_driver(ctrl_enable_driver2), .ctrl_rs(ctrl_rs2), .ctrl_cmd(ctrl_cmd2)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [7:0] arg);
    @(negedge clk);
    cmd_in = op; cmd_arg = arg; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Driver model: answers driver_rdy 3 cycles after enable is first seen
  task automatic serve_byte(output logic [7:0] cmd, output logic rs, output logic [1:0] sel,
                            output logic sel_cnt, output bit seen, output bit stable,
                            output logic en_after);
    seen = 0; stable = 1; en_after = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ctrl_enable_driver) seen = 1;
    end
    cmd = ctrl_cmd; rs = ctrl_rs; sel = ctrl_sel_data; sel_cnt = ctrl_sel_count;
    if (!seen) return;
    repeat (2) begin
      @(negedge clk);
      if (ctrl_cmd !== cmd || ctrl_enable_driver !== 1'b1) stable = 0;
    end
    @(negedge clk);
    if (ctrl_enable_driver !== 1'b1) stable = 0;
    driver_rdy = 1'b1;
    @(negedge clk);
    driver_rdy = 1'b0;
    en_after = ctrl_enable_driver;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready && !busy) ok = 1;
    end
  endtask

  task automatic pulse_flag(input int idx);
    flags_in[idx] = 1'b1;
    @(negedge clk);
    flags_in[idx] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (nctrl_count !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_nctrl: got %b expected 1", nctrl_count); end
    n_checks++; if ({init_done, ctrl_error, ctrl_sel_count, ctrl_sel_data, ctrl_enable_driver, ctrl_rs} !== 7'b0)
      begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000000", {init_done, ctrl_error, ctrl_sel_count, ctrl_sel_data, ctrl_enable_driver, ctrl_rs}); end
    n_checks++; if (ctrl_cmd !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_cmd: got %h expected 00", ctrl_cmd); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_idle: busy %b ready %b expected 0 1", busy, cmd_ready); end
  endtask

  task automatic test_error_before_init();
    logic en_seen;
    issue(4'd2, 8'h05);
    n_checks++; if (ctrl_error !== 1'b1) begin n_fail++; $display("[TB] FAIL early_config_error: got %b expected 1", ctrl_error); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL early_config_idle: ready %b busy %b expected 1 0", cmd_ready, busy); end
    en_seen = 1'b0;
    repeat (3) begin @(negedge clk); en_seen = en_seen | ctrl_enable_driver; end
    n_checks++; if (en_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL early_config_enable: got %b expected 0", en_seen); end
  endtask

  task automatic test_init();
    logic [7:0] exp_bytes [4];
    logic [7:0] c; logic rs, sc, ea; logic [1:0] sel; bit seen, stable, ok;
    exp_bytes = '{8'h28, 8'h06, 8'h0C, 8'h01};
    issue(4'd1, 8'h00);
    n_checks++; if (ctrl_error !== 1'b0) begin n_fail++; $display("[TB] FAIL init_clears_error: got %b expected 0", ctrl_error); end
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL init_accept: busy %b ready %b expected 1 0", busy, cmd_ready); end
    repeat (9) @(negedge clk);
    n_checks++; if ({nctrl_count, ctrl_sel_count, ctrl_enable_driver} !== 3'b000)
      begin n_fail++; $display("[TB] FAIL pwr_wait_ctrl: got %b expected 000", {nctrl_count, ctrl_sel_count, ctrl_enable_driver}); end
    pulse_flag(0);
    for (int b = 0; b < 4; b++) begin
      serve_byte(c, rs, sel, sc, seen, stable, ea);
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL init_enable_%0d: got timeout expected enable", b); end
      n_checks++; if (c !== exp_bytes[b] || rs !== 1'b0 || sel !== 2'b01 || sc !== 1'b1)
        begin n_fail++; $display("[TB] FAIL init_byte_%0d: got cmd %h rs %b sel %b cnt %b expected %h 0 01 1", b, c, rs, sel, sc, exp_bytes[b]); end
      n_checks++; if (!stable || ea !== 1'b0) begin n_fail++; $display("[TB] FAIL init_handshake_%0d: stable %0d enable_after %b expected 1 0", b, stable, ea); end
    end
    n_checks++; if ({nctrl_count, ctrl_sel_count, busy} !== 3'b001)
      begin n_fail++; $display("[TB] FAIL long_wait_ctrl: got %b expected 001", {nctrl_count, ctrl_sel_count, busy}); end
    repeat (4) @(negedge clk);
    n_checks++; if (nctrl_count !== 1'b0) begin n_fail++; $display("[TB] FAIL long_wait_hold: got %b expected 0", nctrl_count); end
    pulse_flag(2);
    n_checks++; if (nctrl_count !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL long_wait_exit: nctrl %b busy %b expected 1 1", nctrl_count, busy); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL init_idle: got timeout expected idle"); end
    n_checks++; if (init_done !== 1'b1 || ctrl_sel_data !== 2'b00 || ctrl_enable_driver !== 1'b0)
      begin n_fail++; $display("[TB] FAIL init_done: done %b sel %b en %b expected 1 00 0", init_done, ctrl_sel_data, ctrl_enable_driver); end
  endtask

  task automatic test_send_data();
    logic [7:0] c; logic rs, sc, ea; logic [1:0] sel; bit seen, stable, ok;
    issue(4'd3, 8'h41);
    serve_byte(c, rs, sel, sc, seen, stable, ea);
    n_checks++; if (!seen || c !== 8'h41 || rs !== 1'b1 || sel !== 2'b10)
      begin n_fail++; $display("[TB] FAIL send_byte: seen %0d cmd %h rs %b sel %b expected 1 41 1 10", seen, c, rs, sel); end
    n_checks++; if (ea !== 1'b0 || nctrl_count !== 1'b1) begin n_fail++; $display("[TB] FAIL send_after: en %b nctrl %b expected 0 1", ea, nctrl_count); end
    wait_idle(ok);
    n_checks++; if (!ok || ctrl_cmd !== 8'h41) begin n_fail++; $display("[TB] FAIL send_hold: idle %0d cmd %h expected 1 41", ok, ctrl_cmd); end
  endtask

  task automatic test_illegal_opcode();
    issue(4'hC, 8'h00);
    n_checks++; if (ctrl_error !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("[TB] FAIL illegal_op: err %b ready %b busy %b expected 1 1 0", ctrl_error, cmd_ready, busy); end
  endtask

  task automatic test_clear_ignores_valid();
    logic [7:0] c; logic rs, sc, ea; logic [1:0] sel; bit seen, stable, ok;
    issue(4'd4, 8'h00);
    n_checks++; if (ctrl_error !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_clears_error: got %b expected 0", ctrl_error); end
    cmd_in = 4'd3; cmd_arg = 8'h55; cmd_valid = 1'b1;
    serve_byte(c, rs, sel, sc, seen, stable, ea);
    n_checks++; if (!seen || c !== 8'h01 || rs !== 1'b0 || sel !== 2'b01)
      begin n_fail++; $display("[TB] FAIL clear_byte: seen %0d cmd %h rs %b sel %b expected 1 01 0 01", seen, c, rs, sel); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || nctrl_count !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_long_wait: busy %b nctrl %b expected 1 0", busy, nctrl_count); end
    cmd_valid = 1'b0;
    pulse_flag(2);
    wait_idle(ok);
    n_checks++; if (!ok || ctrl_cmd !== 8'h01 || ctrl_error !== 1'b0)
      begin n_fail++; $display("[TB] FAIL clear_ignored_req: idle %0d cmd %h err %b expected 1 01 0", ok, ctrl_cmd, ctrl_error); end
  endtask

  task automatic test_commands();
    logic [3:0] ops [4];
    logic [7:0] args [4];
    logic [7:0] exp [4];
    bit         lw [4];
    logic [7:0] c; logic rs, sc, ea; logic [1:0] sel; bit seen, stable, ok;
    ops = '{4'd2, 4'd6, 4'd5, 4'd7};
    args = '{8'h05, 8'h03, 8'h00, 8'h00};
    exp = '{8'h0D, 8'h1C, 8'h02, 8'h08};
    lw = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], args[k]);
      serve_byte(c, rs, sel, sc, seen, stable, ea);
      n_checks++; if (!seen || c !== exp[k] || rs !== 1'b0)
        begin n_fail++; $display("[TB] FAIL cmd_op%0d: seen %0d cmd %h rs %b expected 1 %h 0", ops[k], seen, c, rs, exp[k]); end
      n_checks++; if (nctrl_count !== !lw[k]) begin n_fail++; $display("[TB] FAIL cmd_wait_op%0d: nctrl %b expected %b", ops[k], nctrl_count, !lw[k]); end
      if (lw[k]) pulse_flag(2);
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL cmd_idle_op%0d: got timeout expected idle", ops[k]); end
    end
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("[TB] FAIL off_keeps_init: got %b expected 1", init_done); end
    issue(4'd0, 8'h00);
    n_checks++; if (busy !== 1'b1 || ctrl_enable_driver !== 1'b0) begin n_fail++; $display("[TB] FAIL nop_done: busy %b en %b expected 1 0", busy, ctrl_enable_driver); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL nop_idle: busy %b ready %b expected 0 1", busy, cmd_ready); end
  endtask

  task automatic test_reset_mid_issue();
    logic [7:0] c; logic rs, sc, ea; logic [1:0] sel; bit seen, stable;
    issue(4'd1, 8'h00);
    repeat (2) @(negedge clk);
    pulse_flag(0);
    serve_byte(c, rs, sel, sc, seen, stable, ea);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ctrl_enable_driver) seen = 1;
    end
    n_checks++; if (!seen || ctrl_cmd !== 8'h06) begin n_fail++; $display("[TB] FAIL rst_issue_06: seen %0d cmd %h expected 1 06", seen, ctrl_cmd); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({cmd_ready, busy, init_done, ctrl_error, nctrl_count, ctrl_sel_count, ctrl_sel_data, ctrl_enable_driver, ctrl_rs} !== 10'b1000100000)
      begin n_fail++; $display("[TB] FAIL rst_async_outputs: got %b expected 1000100000", {cmd_ready, busy, init_done, ctrl_error, nctrl_count, ctrl_sel_count, ctrl_sel_data, ctrl_enable_driver, ctrl_rs}); end
    n_checks++; if (ctrl_cmd !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_async_cmd: got %h expected 00", ctrl_cmd); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ctrl_enable_driver !== 1'b0 || init_done !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rst_no_resume: busy %b en %b done %b expected 0 0 0", busy, ctrl_enable_driver, init_done); end
  endtask

  task automatic test_setup_alt();
    bit seen;
    @(negedge clk);
    cmd_in = 4'd1; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    pulse_flag(0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ctrl_enable_driver2) seen = 1;
    end
    n_checks++; if (!seen || ctrl_cmd2 !== 8'h34 || ctrl_rs2 !== 1'b0 || ctrl_sel_data2 !== 2'b01)
      begin n_fail++; $display("[TB] FAIL alt_setup: seen %0d cmd %h rs %b sel %b expected 1 34 0 01", seen, ctrl_cmd2, ctrl_rs2, ctrl_sel_data2); end
  endtask

  initial begin
    $display("[TB] starting lcd_cmd_sequencer bench");
    test_reset();
    test_error_before_init();
    test_init();
    test_send_data();
    test_illegal_opcode();
    test_clear_ignores_valid();
    test_commands();
    test_reset_mid_issue();
    test_setup_alt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
